// File: rtl/fpc_pkg.sv
// Shared types and bfloat16 field constants for the float/integer conversion blocks.
package fpc_pkg;

  localparam int BF16_BIAS  = 127;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_EXP_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_OUT
  } state_e;

  typedef enum logic [1:0] {
    ZERO,
    NAN,
    SAT,
    NORM
  } cls_e;

endpackage

// File: rtl/bf16_unpack.sv
// Combinational bfloat16 field decode: sign, hidden-bit mantissa, class,
// and the shift direction/count that aligns the mantissa to an integer.
module bf16_unpack
  import fpc_pkg::*;
#(
  parameter int INT_W = 16,
  parameter int CNT_W = 5
) (
  input  logic [15:0]           in_data,
  output logic                  s,
  output logic [BF16_MAN_W:0]   m,
  output cls_e                  cls,
  output logic                  dir_left,
  output logic [CNT_W-1:0]      n
);

  logic [BF16_EXP_W-1:0] e;
  logic [BF16_MAN_W-1:0] frac;

  assign e    = in_data[14 -: BF16_EXP_W];
  assign frac = in_data[BF16_MAN_W-1:0];
  assign s    = in_data[15];
  assign m    = {1'b1, frac};

  always_comb begin
    int k;
    // NOTE: every output gets a default before any branch so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    k        = int'(e) - BF16_BIAS;
    cls      = ZERO;
    dir_left = 1'b0;
    n        = '0;
    if (e == '1) begin
      cls = (frac != '0) ? NAN : SAT;
    end else if (e == '0 || k < 0) begin
      cls = ZERO;
    end else if (k >= INT_W - 1) begin
      cls = SAT;
    end else begin
      // The mantissa already carries 7 fractional bits, so k==7 needs no shift.
      cls      = NORM;
      dir_left = (k >= BF16_MAN_W);
      n        = CNT_W'(dir_left ? (k - BF16_MAN_W) : (BF16_MAN_W - k));
    end
  end

endmodule

// File: rtl/bf16_to_int.sv
// bfloat16 to signed integer converter: round toward zero, saturating, with an
// iterative one-bit-per-cycle shifter and a pulse handshake.
module bf16_to_int
  import fpc_pkg::*;
#(
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [INT_W-1:0] out
);

  localparam int CNT_W = $clog2(INT_W) + 1;
  localparam logic [INT_W-1:0] SAT_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SAT_NEG = {1'b1, {(INT_W-1){1'b0}}};

  logic                u_s;
  logic [BF16_MAN_W:0] u_m;
  cls_e                u_cls;
  logic                u_left;
  logic [CNT_W-1:0]    u_n;

  bf16_unpack #(
    .INT_W (INT_W),
    .CNT_W (CNT_W)
  ) u_unpack (
    .in_data  (in_data),
    .s        (u_s),
    .m        (u_m),
    .cls      (u_cls),
    .dir_left (u_left),
    .n        (u_n)
  );

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic             s_q, s_d;
  logic             left_q, left_d;
  logic [INT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [INT_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  assign in_ready  = (state_q == S_IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    s_d         = s_q;
    left_d      = left_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = '0;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cls_d   = u_cls;
          s_d     = u_s;
          left_d  = u_left;
          acc_d   = {{(INT_W-BF16_MAN_W-1){1'b0}}, u_m};
          cnt_d   = u_n;
          state_d = (u_cls == NORM && u_n != '0) ? S_SHIFT : S_OUT;
        end
      end
      S_SHIFT: begin
        acc_d = left_q ? (acc_q << 1) : (acc_q >> 1);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_OUT;
      end
      S_OUT: begin
        // Magnitude is at most 2^(INT_W-1)-1 here, so the negation cannot wrap.
        case (cls_q)
          NORM:    out_d = s_q ? -acc_q : acc_q;
          SAT:     out_d = s_q ? SAT_NEG : SAT_POS;
          default: out_d = '0;
        endcase
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cls_q       <= ZERO;
      s_q         <= 1'b0;
      left_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      s_q         <= s_d;
      left_q      <= left_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bf16_to_int.sv
// Scoreboard bench for bf16_to_int: a driver pushes reference results, a
// negedge monitor pops and compares value and arrival edge.
module tb_bf16_to_int;

  localparam int INT_W = 16;

  typedef struct {
    logic [INT_W-1:0] val;
    int               edge_no;
    logic [15:0]      din;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [15:0]      in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [INT_W-1:0] out;

  int   n_checks = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  exp_t sb[$];

  bf16_to_int #(.INT_W(INT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: real value of the bfloat16, truncated toward zero, clamped to
  // the signed INT_W range. Latency is one edge per alignment shift plus one.
  function automatic void model(input logic [15:0] d, output logic [INT_W-1:0] v,
                                output int lat);
    longint maxv, mag;
    int     k;
    logic   s;
    logic [7:0] e;
    logic [6:0] f;
    s    = d[15];
    e    = d[14:7];
    f    = d[6:0];
    maxv = (64'sd1 <<< (INT_W - 1)) - 1;
    lat  = 1;
    v    = '0;
    k    = int'(e) - 127;
    if (e == 8'hFF && f != 0) begin
      v = '0;
    end else if (e == 8'hFF || (e != 0 && k > 40)) begin
      v = s ? INT_W'(-maxv - 1) : INT_W'(maxv);
    end else if (e == 0 || k < 0) begin
      v = '0;
    end else begin
      mag = (longint'({1'b1, f}) << k) / 128;
      if (mag > maxv) begin
        v = s ? INT_W'(-maxv - 1) : INT_W'(maxv);
      end else begin
        v   = s ? INT_W'(-mag) : INT_W'(mag);
        lat = ((k >= 7) ? (k - 7) : (7 - k)) + 1;
      end
    end
  endfunction

  // Called at a negedge; waits for in_ready, drives for one cycle, returns at
  // the following negedge.
  task automatic send(input logic [15:0] d);
    exp_t x;
    int   lat;
    int   budget;
    budget = 0;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      return;
    end
    model(d, x.val, lat);
    x.edge_no = edge_cnt + 1 + lat;
    x.din     = d;
    sb.push_back(x);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        x = sb.pop_front();
        check($sformatf("out[%04h]", x.din), 64'(out), 64'(x.val));
        check($sformatf("latency[%04h]", x.din), 64'(edge_cnt), 64'(x.edge_no));
      end
    end else if (out !== '0) begin
      check("out_idle_zero", 64'(out), 64'd0);
    end
  end

  logic [15:0] directed [16] = '{
    16'h4300, 16'h3F80, 16'h40B0, 16'hC0B0, 16'hC6FF, 16'h4700, 16'hFF80, 16'h7FC0,
    16'h8000, 16'h0001, 16'h3F00, 16'hBF00, 16'h7F80, 16'h46FF, 16'hC700, 16'h4000
  };

  initial begin
    logic [15:0] d;
    int          budget;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out", 64'(out), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (directed[i]) send(directed[i]);

    // Operand offered while busy is dropped.
    send(16'h3F80);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = 16'h4300;
    @(negedge clk);
    in_valid = 1'b0;

    // Operand offered in the out_valid cycle is accepted.
    budget = 0;
    while (!out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("pulse_seen", 64'(out_valid), 64'd1);
    check("ready_in_pulse", 64'(in_ready), 64'd1);
    send(16'h40B0);

    // Reset at edge 3 of a conversion discards it.
    while (!in_ready) @(negedge clk);
    send(16'h3F80);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    send(16'h3F80);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) d = 16'($urandom);
      else d = {1'($urandom), 8'($urandom_range(120, 145)), 7'($urandom)};
      send(d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bf16_to_int.md
Name: bf16_to_int

Overview:
- Decodes a bfloat16 value into a signed two's-complement integer, the inverse direction of the team's bfloat16 add/multiply encoder.
- Sits downstream of that unit and consumes its 16-bit bfloat16 results.
- Uses an iterative barrel-free shifter: one mantissa bit per cycle, so latency depends on the exponent.
- Rounds toward zero, saturates on overflow, and uses an in_valid/out_valid pulse handshake plus a ready indication.

Parameters:
- INT_W, 16: output integer width. Legal range 9..32. All saturation and shift limits derive from it.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand strobe; sampled only when in_ready=1
- in_data  input  16  bfloat16 operand {sign[15], exp[14:7], frac[6:0]}
- in_ready  output  1  combinational; 1 iff FSM is in S_IDLE
- out_valid  output  1  registered; one-cycle result pulse
- out  output  INT_W  registered signed result; 0 whenever out_valid=0

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=S_IDLE, out=0, out_valid=0, all internal registers 0.
  - Reset mid-conversion discards the operand; no out_valid pulse follows.
- Field decode at capture:
  - s=in_data[15], e=in_data[14:7], m={1,in_data[6:0]} (8 bits), k=e-127 (signed).
- Classification, decided at capture:
  - ZERO: e==0 (zero or subnormal, flushed) or k<0 → result 0.
  - NAN: e==255 with frac!=0 → result 0.
  - SAT: e==255 with frac==0, or k>=INT_W-1 → result s ? -2^(INT_W-1) : 2^(INT_W-1)-1.
  - NORM: 0<=k<=INT_W-2. Magnitude = m shifted left by (k-7) if k>=7, else right by (7-k) with truncation. Shift count n=|k-7|.
  - Negative zero and any negative result that truncates to 0 → out=0.
- FSM states S_IDLE, S_SHIFT, S_OUT:
  - S_IDLE, in_valid=1: latch class, s, and acc=zero-extended m (INT_W bits). Load cnt=n and direction. Go to S_SHIFT if class NORM and n>0, else S_OUT.
  - S_IDLE, in_valid=0: stay.
  - S_SHIFT: acc shifts one bit in the latched direction per cycle and cnt decrements. When cnt==1, go to S_OUT.
  - S_OUT: compute out_next (NORM: s ? -acc : acc; others per class). Go to S_IDLE.
  - Next edge: out<=out_next and out_valid<=1 for exactly one cycle; otherwise out<=0 and out_valid<=0.
- Latency: out_valid is high in the cycle after edge n+1, counting the capture edge as edge 0.
  - Specials and k==7: 1 edge.
  - Maximum: max(7, INT_W-9)+1 edges.
- Handshake rules:
  - in_valid while in_ready=0 is ignored, with no buffering.
  - in_valid in the same cycle that out_valid is high is accepted, since the FSM is already in S_IDLE.
  - Sustained throughput is one conversion per n+2 cycles.
- Width rules:
  - acc and cnt are sized for INT_W.
  - The NORM left-shift maximum is INT_W-9 bits. The magnitude never exceeds 2^(INT_W-1)-1, so negation never overflows.

Decomposition:
- Shared package fpc_pkg holds:
  - the state enum (S_IDLE, S_SHIFT, S_OUT)
  - the class enum (ZERO, NAN, SAT, NORM)
  - BF16_BIAS=127, BF16_MAN_W=7, BF16_EXP_W=8
- One combinational sub-module, bf16_unpack:
  - inputs: in_data, INT_W
  - outputs: s, m, class, shift direction, n
- The top level keeps the FSM, shifter, and output register.

Test Plan:
- 0x4300 (128.0, k=7) → out=0x0080, out_valid 1 edge after capture.
- 0x3F80 (1.0) → out=0x0001 after 8 edges. 0x40B0 (5.5) → 0x0005 after 6 edges. 0xC0B0 → 0xFFFB (-5).
- 0xC6FF (-32640, k=14, n=7) → 0x8080 after 8 edges. 0x4700 (32768.0) → 0x7FFF and 0xFF80 (-inf) → 0x8000, each after 1 edge.
- 0x7FC0 (NaN), 0x8000 (-0), 0x0001 (subnormal), 0x3F00 (0.5), 0xBF00 (-0.5) → out=0x0000 each, out_valid pulses.
- 0x3F80 issued, then 0x4300 on the next cycle while in_ready=0 → only one pulse (0x0001). A new operand asserted in the out_valid cycle is accepted, and its result follows.
- rst_n dropped at edge 3 of a 0x3F80 conversion → out=0 and out_valid=0 immediately, no later pulse. The next operand after reset converts normally.
